// File: rtl/axi_dma_mem_slave.sv
// AXI4 slave memory with independent INCR/FIXED read and write engines; WRAP/reserved/oversize bursts get SLVERR.
// Optional AXI_DMA_MEM_SLAVE_THROTTLE_EN gates ARREADY/AWREADY/WREADY/RVALID from a 16-bit LFSR.
module axi_dma_mem_slave #(
  parameter int ADDR_WD        = 32,
  parameter int DATA_WD        = 32,
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 S_AXI_ARVALID,
  output logic                 S_AXI_ARREADY,
  input  logic [ADDR_WD-1:0]   S_AXI_ARADDR,
  input  logic [7:0]           S_AXI_ARLEN,
  input  logic [2:0]           S_AXI_ARSIZE,
  input  logic [1:0]           S_AXI_ARBURST,
  output logic                 S_AXI_RVALID,
  input  logic                 S_AXI_RREADY,
  output logic [DATA_WD-1:0]   S_AXI_RDATA,
  output logic [1:0]           S_AXI_RRESP,
  output logic                 S_AXI_RLAST,
  input  logic                 S_AXI_AWVALID,
  output logic                 S_AXI_AWREADY,
  input  logic [ADDR_WD-1:0]   S_AXI_AWADDR,
  input  logic [7:0]           S_AXI_AWLEN,
  input  logic [2:0]           S_AXI_AWSIZE,
  input  logic [1:0]           S_AXI_AWBURST,
  input  logic                 S_AXI_WVALID,
  output logic                 S_AXI_WREADY,
  input  logic [DATA_WD-1:0]   S_AXI_WDATA,
  input  logic [DATA_WD/8-1:0] S_AXI_WSTRB,
  input  logic                 S_AXI_WLAST,
  output logic                 S_AXI_BVALID,
  input  logic                 S_AXI_BREADY,
  output logic [1:0]           S_AXI_BRESP
);
  localparam int STRB_WD = DATA_WD / 8;
  localparam int SL      = $clog2(STRB_WD);
  localparam int DEPTH   = 1 << MEM_WORDS_LOG2;
  localparam logic [1:0] RESP_OK = 2'b00, RESP_SLV = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00, BURST_INCR = 2'b01;

  typedef enum logic { R_IDLE, R_DATA } r_state_t;
  typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } w_state_t;

  logic [DATA_WD-1:0] mem [0:DEPTH-1];

  function automatic logic bad_burst(input logic [1:0] b, input logic [2:0] s);
    return !(b == BURST_FIXED || b == BURST_INCR) || (s > 3'(SL));
  endfunction

  function automatic logic [ADDR_WD-1:0] next_addr(input logic [ADDR_WD-1:0] a,
                                                   input logic [1:0] b, input logic [2:0] s);
    return (b == BURST_FIXED) ? a : a + (ADDR_WD'(1) << s);
  endfunction

  function automatic logic [MEM_WORDS_LOG2-1:0] widx(input logic [ADDR_WD-1:0] a);
    return a[SL +: MEM_WORDS_LOG2];
  endfunction

  logic ar_gate, aw_gate, w_gate, r_gate;
`ifdef AXI_DMA_MEM_SLAVE_THROTTLE_EN
  logic [15:0] lfsr;
  logic        r_hold;
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= 16'hACE1;
      r_hold <= 1'b0;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      r_hold <= S_AXI_RVALID && !S_AXI_RREADY;
    end
  end
  assign ar_gate = |lfsr[1:0];
  assign aw_gate = |lfsr[3:2];
  // a presented-but-unaccepted RVALID must stay up regardless of the LFSR
  assign r_gate  = (|lfsr[5:4]) || r_hold;
  assign w_gate  = |lfsr[7:6];
`else
  assign ar_gate = 1'b1;
  assign aw_gate = 1'b1;
  assign r_gate  = 1'b1;
  assign w_gate  = 1'b1;
`endif

  // ---------------- read engine ----------------
  r_state_t           r_state;
  logic [ADDR_WD-1:0] r_addr, r_next;
  logic [7:0]         r_len, r_cnt;
  logic [2:0]         r_size;
  logic [1:0]         r_burst, rresp_q;
  logic               r_bad, rlast_q;
  logic [DATA_WD-1:0] rdata_q;
  logic               ar_hs, r_hs;

  assign S_AXI_ARREADY = !rst && (r_state == R_IDLE) && ar_gate;
  assign S_AXI_RVALID  = !rst && (r_state == R_DATA) && r_gate;
  assign S_AXI_RDATA   = rst ? '0 : rdata_q;
  assign S_AXI_RRESP   = rst ? 2'b00 : rresp_q;
  assign S_AXI_RLAST   = !rst && rlast_q;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs   = S_AXI_RVALID && S_AXI_RREADY;
  assign r_next = next_addr(r_addr, r_burst, r_size);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_bad   <= 1'b0;
      r_cnt   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OK;
      rlast_q <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_addr  <= S_AXI_ARADDR;
          r_len   <= S_AXI_ARLEN;
          r_size  <= S_AXI_ARSIZE;
          r_burst <= S_AXI_ARBURST;
          r_bad   <= bad_burst(S_AXI_ARBURST, S_AXI_ARSIZE);
          r_cnt   <= '0;
          rlast_q <= (S_AXI_ARLEN == 8'd0);
          rresp_q <= bad_burst(S_AXI_ARBURST, S_AXI_ARSIZE) ? RESP_SLV : RESP_OK;
          rdata_q <= bad_burst(S_AXI_ARBURST, S_AXI_ARSIZE) ? '0 : mem[widx(S_AXI_ARADDR)];
          r_state <= R_DATA;
        end
        default: if (r_hs) begin
          if (rlast_q) begin
            rlast_q <= 1'b0;
            r_state <= R_IDLE;
          end else begin
            // next beat is fetched at this handshake, so a write landing now is not seen
            r_cnt   <= r_cnt + 8'd1;
            r_addr  <= r_next;
            rlast_q <= ((r_cnt + 8'd1) == r_len);
            rdata_q <= r_bad ? '0 : mem[widx(r_next)];
          end
        end
      endcase
    end
  end

  // ---------------- write engine ----------------
  w_state_t           w_state;
  logic [ADDR_WD-1:0] w_addr;
  logic [7:0]         w_len, w_cnt;
  logic [2:0]         w_size;
  logic [1:0]         w_burst, bresp_q;
  logic               w_bad, w_err, w_over, w_at_len, w_proto, w_we;
  logic               aw_hs, w_hs, b_hs;

  assign S_AXI_AWREADY = !rst && (w_state == W_IDLE) && aw_gate;
  assign S_AXI_WREADY  = !rst && (w_state == W_DATA) && w_gate;
  assign S_AXI_BVALID  = !rst && (w_state == W_RESP);
  assign S_AXI_BRESP   = rst ? 2'b00 : bresp_q;
  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs     = S_AXI_BVALID && S_AXI_BREADY;
  assign w_at_len = (w_cnt == w_len);
  assign w_proto  = (S_AXI_WLAST != w_at_len);
  assign w_we     = w_hs && !w_bad && !w_over;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_bad   <= 1'b0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      w_over  <= 1'b0;
      bresp_q <= RESP_OK;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_addr  <= S_AXI_AWADDR;
          w_len   <= S_AXI_AWLEN;
          w_size  <= S_AXI_AWSIZE;
          w_burst <= S_AXI_AWBURST;
          w_bad   <= bad_burst(S_AXI_AWBURST, S_AXI_AWSIZE);
          w_cnt   <= '0;
          w_err   <= 1'b0;
          w_over  <= 1'b0;
          w_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          if (S_AXI_WLAST) begin
            bresp_q <= (w_bad || w_err || (!w_over && w_proto)) ? RESP_SLV : RESP_OK;
            w_state <= W_RESP;
          end else if (!w_over) begin
            // beat len without WLAST: stop writing, drain until WLAST
            if (w_at_len) w_over <= 1'b1;
            else begin
              w_cnt  <= w_cnt + 8'd1;
              w_addr <= next_addr(w_addr, w_burst, w_size);
            end
            if (w_proto) w_err <= 1'b1;
          end
        end
        default: if (b_hs) w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < STRB_WD; b++) begin
        if (S_AXI_WSTRB[b]) mem[widx(w_addr)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_dma_mem_slave.sv
// Directed bench for axi_dma_mem_slave: stimulus pushes expected R beats / B responses, monitors pop and compare.
module tb_axi_dma_mem_slave;
  localparam logic [1:0] OK = 2'b00, SLV = 2'b10;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic [3:0]  wstrb;

  axi_dma_mem_slave #(.ADDR_WD(32), .DATA_WD(32), .MEM_WORDS_LOG2(10)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr),
    .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp)
  );

  typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  rbeat_t     rq[$];
  logic [1:0] bq[$];
  int n_cmp = 0, n_err = 0;
  logic [31:0] wd [0:31];
  logic [3:0]  ws [0:31];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic l);
    rq.push_back({d, r, l});
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wd[i] = base + 32'(i);
      ws[i] = 4'hF;
    end
  endtask

  // read-beat monitor and hold-stability monitor
  rbeat_t r_exp;
  logic   prev_stall = 1'b0;
  logic [34:0] held;
  always @(negedge clk) begin
    if (!rst && rvalid && prev_stall)
      check("r_hold_stable", {29'd0, rdata, rresp, rlast}, {29'd0, held});
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL r_unexpected: got %h expected no beat", rdata);
      end else begin
        r_exp = rq.pop_front();
        check("r_beat", {29'd0, rdata, rresp, rlast}, {29'd0, r_exp});
      end
    end
    prev_stall = !rst && rvalid && !rready;
    held       = {rdata, rresp, rlast};
  end

  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected: got %h expected no response", bresp);
      end else check("bresp", 64'(bresp), 64'(bq.pop_front()));
    end
  end

  task automatic wait_drain();
    int t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(t >= 200), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                    input int nbeats, input logic [1:0] exp);
    int t;
    bq.push_back(exp);
    awaddr = a; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!awready && t < 100) begin @(negedge clk); t++; end
    check("aw_timeout", 64'(t >= 100), 64'd0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!wready && t < 100) begin @(negedge clk); t++; end
      check("w_timeout", 64'(t >= 100), 64'd0);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    wait_drain();
  endtask

  // expected beats are pushed by the caller; RREADY drops for stall_cyc cycles after stall_after beats
  task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                    input logic [2:0] size, input int stall_after, input int stall_cyc);
    int t, beats, cyc, stalled;
    araddr = a; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < 100) begin @(negedge clk); t++; end
    check("ar_timeout", 64'(t >= 100), 64'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("r_first_latency", 64'(rvalid), 64'd1);
    beats = 0; cyc = 0; stalled = 0; t = 0;
    while (beats <= int'(len) && t < 400) begin
      if (rvalid) cyc++;
      if (rvalid && rready) beats++;
      t++;
      if (beats <= int'(len)) begin
        @(posedge clk); #1;
        if (beats == stall_after && stalled < stall_cyc) begin rready = 1'b0; stalled++; end
        else rready = 1'b1;
        @(negedge clk);
      end
    end
    check("r_cycles", 64'(cyc), 64'(int'(len) + 1 + stall_cyc));
    @(negedge clk);
    check("ar_ready_after_last", 64'(arready), 64'd1);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 1'b1;
    awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", {arready, awready, rvalid, rlast, wready, bvalid, rdata, rresp, bresp},
            64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {62'd0, arready, awready}, 64'd3);
    @(posedge clk); #1;

    // INCR 4-beat write then read
    fill(32'd1, 4);
    wr(32'h100, 8'd3, INCR, 4, OK);
    for (int i = 0; i < 4; i++) push_r(32'(i + 1), OK, i == 3);
    rd(32'h100, 8'd3, INCR, 3'd2, -1, 0);

    // strobed write
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    wr(32'h40, 8'd0, INCR, 1, OK);
    wd[0] = 32'h1234_5678; ws[0] = 4'b0101;
    wr(32'h40, 8'd0, INCR, 1, OK);
    push_r(32'hFF34_FF78, OK, 1'b1);
    rd(32'h40, 8'd0, INCR, 3'd2, -1, 0);

    // 16 beats with a 5-cycle RREADY stall
    fill(32'h1000, 16);
    wr(32'h200, 8'd15, INCR, 16, OK);
    for (int i = 0; i < 16; i++) push_r(32'h1000 + 32'(i), OK, i == 15);
    rd(32'h200, 8'd15, INCR, 3'd2, 6, 5);

    // WLAST early, then WLAST late (writes stop at beat len)
    fill(32'hC0, 4);
    wr(32'h380, 8'd3, INCR, 2, SLV);
    fill(32'hA0, 4);
    wr(32'h300, 8'd3, INCR, 4, OK);
    fill(32'hB0, 4);
    wr(32'h300, 8'd1, INCR, 4, SLV);
    push_r(32'hB0, OK, 0); push_r(32'hB1, OK, 0); push_r(32'hA2, OK, 0); push_r(32'hA3, OK, 1);
    rd(32'h300, 8'd3, INCR, 3'd2, -1, 0);

    // WRAP read returns zeros with SLVERR; WRAP write touches nothing
    push_r(32'd0, SLV, 0); push_r(32'd0, SLV, 1);
    rd(32'h100, 8'd1, WRAP, 3'd2, -1, 0);
    wd[0] = 32'h55; ws[0] = 4'hF;
    wr(32'h100, 8'd0, WRAP, 1, SLV);
    push_r(32'd1, OK, 1);
    rd(32'h100, 8'd0, INCR, 3'd2, -1, 0);

    // oversize read
    push_r(32'd0, SLV, 1);
    rd(32'h100, 8'd0, INCR, 3'd3, -1, 0);

    // FIXED burst holds the address
    fill(32'h7, 3);
    wr(32'h80, 8'd2, FIXED, 3, OK);
    push_r(32'h9, OK, 0); push_r(32'h9, OK, 1);
    rd(32'h80, 8'd1, FIXED, 3'd2, -1, 0);

    // aliasing modulo array size
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    wr(32'h0000_1000, 8'd0, INCR, 1, OK);
    push_r(32'hDEAD_BEEF, OK, 1);
    rd(32'h0000_0000, 8'd0, INCR, 3'd2, -1, 0);

    // same-cycle read and write of one word: read-first
    wd[0] = 32'h1111_1111; ws[0] = 4'hF;
    wr(32'h500, 8'd0, INCR, 1, OK);
    push_r(32'h1111_1111, OK, 1);
    bq.push_back(OK);
    awaddr = 32'h500; awlen = 0; awburst = INCR; awsize = 3'd2; awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!awready && t < 100) begin @(negedge clk); t++; end
    check("aw_timeout", 64'(t >= 100), 64'd0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    araddr = 32'h500; arlen = 0; arburst = INCR; arsize = 3'd2; arvalid = 1'b1; rready = 1'b1;
    wdata = 32'h2222_2222; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("concurrent_ready", {62'd0, arready, wready}, 64'd3);
    @(posedge clk); #1;
    arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    wait_drain();
    push_r(32'h2222_2222, OK, 1);
    rd(32'h500, 8'd0, INCR, 3'd2, -1, 0);

    // reset mid-read
    araddr = 32'h200; arlen = 8'd15; arburst = INCR; arsize = 3'd2; arvalid = 1'b1; rready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!arready && t < 100) begin @(negedge clk); t++; end
    check("ar_timeout", 64'(t >= 100), 64'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_before_rst", 64'(rvalid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_read", {61'd0, rvalid, arready, rlast}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_release", {62'd0, arready, rvalid}, 64'd2);
    @(posedge clk); #1;
    rready = 1'b1;

    check("queues_empty", 64'(rq.size() + bq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
